bicubic_coord_gen: RTL

//  Destination-raster scanner for the bicubic resize engine. It latches one frame

---
 rtl/bicubic_coord_gen.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bicubic_coord_gen.sv
// Destination-raster scanner for the bicubic resize engine: walks destination pixels
// row-major and presents (a*b)/c operand sets for the X and Y coordinate mappers.
module bicubic_coord_gen #(
    parameter int A_W = 7,
    parameter int B_W = 5,
    parameter int C_W = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [B_W:0]   src_w_i,
    input  logic [B_W:0]   src_h_i,
    input  logic [A_W-1:0] dst_w_i,
    input  logic [A_W-1:0] dst_h_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           cfg_err_o,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [A_W-1:0] x_a_o,
    output logic [B_W-1:0] x_b_o,
    output logic [C_W-1:0] x_c_o,
    output logic [A_W-1:0] y_a_o,
    output logic [B_W-1:0] y_b_o,
    output logic [C_W-1:0] y_c_o,
    output logic           row_last_o,
    output logic           frame_last_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [B_W:0]   SRC_MAX = (B_W+1)'(2**B_W);
    localparam logic [A_W-1:0] DST_MAX = A_W'(2**(A_W-1));

    logic [1:0]     state_q, state_d;
    logic [C_W-1:0] xCnt_q, xCnt_d;
    logic [C_W-1:0] yCnt_q, yCnt_d;
    logic [C_W-1:0] xSpan_q, xSpan_d;
    logic [C_W-1:0] ySpan_q, ySpan_d;
    logic [B_W-1:0] xB_q, xB_d;
    logic [B_W-1:0] yB_q, yB_d;
    logic [C_W-1:0] xC_q, xC_d;
    logic [C_W-1:0] yC_q, yC_d;
    logic           cfgErr_q, cfgErr_d;

    logic           cfgLegal;
    logic [C_W-1:0] dstWm1;
    logic [C_W-1:0] dstHm1;
    logic [B_W-1:0] srcWm1;
    logic [B_W-1:0] srcHm1;
    logic           transfer;
    logic           rowEnd;
    logic           frameEnd;

    assign cfgLegal = (src_w_i != '0) && (src_w_i <= SRC_MAX) &&
                      (src_h_i != '0) && (src_h_i <= SRC_MAX) &&
                      (dst_w_i != '0) && (dst_w_i <= DST_MAX) &&
                      (dst_h_i != '0) && (dst_h_i <= DST_MAX);

    // Truncating before the decrement maps the maximum size (2**N) to all-ones correctly.
    assign dstWm1 = C_W'(dst_w_i) - C_W'(1);
    assign dstHm1 = C_W'(dst_h_i) - C_W'(1);
    assign srcWm1 = B_W'(src_w_i) - B_W'(1);
    assign srcHm1 = B_W'(src_h_i) - B_W'(1);

    assign transfer = (state_q == ST_RUN) && out_ready_i;
    assign rowEnd   = (xCnt_q == xSpan_q);
    assign frameEnd = rowEnd && (yCnt_q == ySpan_q);

    always_comb begin
        state_d  = state_q;
        xCnt_d   = xCnt_q;
        yCnt_d   = yCnt_q;
        xSpan_d  = xSpan_q;
        ySpan_d  = ySpan_q;
        xB_d     = xB_q;
        yB_d     = yB_q;
        xC_d     = xC_q;
        yC_d     = yC_q;
        cfgErr_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (cfgLegal) begin
                        state_d = ST_RUN;
                        xCnt_d  = '0;
                        yCnt_d  = '0;
                        xSpan_d = dstWm1;
                        ySpan_d = dstHm1;
                        xB_d    = srcWm1;
                        yB_d    = srcHm1;
                        // A unit-size axis divides by 1 instead of 0; its index stays 0.
                        xC_d    = (dstWm1 == '0) ? C_W'(1) : dstWm1;
                        yC_d    = (dstHm1 == '0) ? C_W'(1) : dstHm1;
                    end else begin
                        cfgErr_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (transfer) begin
                    if (frameEnd) begin
                        state_d = ST_DONE;
                    end
                    if (rowEnd) begin
                        xCnt_d = '0;
                        yCnt_d = yCnt_q + C_W'(1);
                    end else begin
                        xCnt_d = xCnt_q + C_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            xCnt_q   <= '0;
            yCnt_q   <= '0;
            xSpan_q  <= '0;
            ySpan_q  <= '0;
            xB_q     <= '0;
            yB_q     <= '0;
            xC_q     <= '0;
            yC_q     <= '0;
            cfgErr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            xCnt_q   <= xCnt_d;
            yCnt_q   <= yCnt_d;
            xSpan_q  <= xSpan_d;
            ySpan_q  <= ySpan_d;
            xB_q     <= xB_d;
            yB_q     <= yB_d;
            xC_q     <= xC_d;
            yC_q     <= yC_d;
            cfgErr_q <= cfgErr_d;
        end
    end

    assign busy_o       = (state_q == ST_RUN);
    assign out_valid_o  = (state_q == ST_RUN);
    assign done_o       = (state_q == ST_DONE);
    assign cfg_err_o    = cfgErr_q;
    assign row_last_o   = out_valid_o && rowEnd;
    assign frame_last_o = out_valid_o && frameEnd;

    assign x_a_o = A_W'(xCnt_q);
    assign x_b_o = xB_q;
    assign x_c_o = xC_q;
    assign y_a_o = A_W'(yCnt_q);
    assign y_b_o = yB_q;
    assign y_c_o = yC_q;

endmodule
